// File: rtl/ram_4x4_seq.sv
// ram_4x4_seq: valid/ready request sequencer that registers the ram_4x4 pins and returns read data.
// Macro RAM_SEQ_CLEAR_EN adds a post-reset sweep that zeroes every word before traffic is accepted.
module ram_4x4_seq #(
  parameter int AW = 4,
  parameter int DW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ_VALID,
  output logic          REQ_READY,
  input  logic          REQ_WR,
  input  logic [AW-1:0] REQ_ADDR,
  input  logic [DW-1:0] REQ_DATA,
  output logic          RSP_VALID,
  output logic [DW-1:0] RSP_DATA,
  output logic          RAM_EN,
  output logic          RAM_WR,
  output logic [AW-1:0] RAM_A,
  output logic [DW-1:0] RAM_D,
  input  logic [DW-1:0] RAM_Q,
  output logic          BUSY
);
  logic          clr;
  logic [AW-1:0] clr_a;
  logic          acc;
  logic          en_q, en_d, wr_q, wr_d, rsp_vld_q, rsp_vld_d;
  logic [AW-1:0] a_q, a_d;
  logic [DW-1:0] d_q, d_d, rsp_q, rsp_d;
  logic [1:0]    pipe_q, pipe_d;
`ifdef RAM_SEQ_CLEAR_EN
  typedef enum logic {CLEAR, IDLE} state_e;
  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  // counter saturates on the last address; leaving CLEAR happens on that same edge
  always_comb begin
    state_d = (state_q == CLEAR && cnt_q == '1) ? IDLE : state_q;
    cnt_d   = (state_q == CLEAR && cnt_q != '1) ? cnt_q + AW'(1) : cnt_q;
  end
  assign clr   = state_q == CLEAR;
  assign clr_a = cnt_q;
`else
  assign clr   = 1'b0;
  assign clr_a = '0;
`endif
  assign REQ_READY = ~clr;
  assign BUSY      = clr;
  assign acc       = REQ_VALID & REQ_READY;
  // reads flow through a 2-stage valid pipe so RAM_Q is captured after the RAM has sampled
  always_comb begin
    en_d      = clr | acc;
    wr_d      = clr | (acc & REQ_WR);
    a_d       = clr ? clr_a : acc ? REQ_ADDR : a_q;
    d_d       = clr ? '0 : (acc & REQ_WR) ? REQ_DATA : d_q;
    pipe_d    = {pipe_q[0], acc & ~REQ_WR};
    rsp_vld_d = pipe_q[1];
    rsp_d     = pipe_q[1] ? RAM_Q : rsp_q;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      en_q      <= 1'b0;
      wr_q      <= 1'b0;
      a_q       <= '0;
      d_q       <= '0;
      pipe_q    <= '0;
      rsp_vld_q <= 1'b0;
      rsp_q     <= '0;
    end else begin
      en_q      <= en_d;
      wr_q      <= wr_d;
      a_q       <= a_d;
      d_q       <= d_d;
      pipe_q    <= pipe_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_q     <= rsp_d;
    end
  assign RAM_EN    = en_q;
  assign RAM_WR    = wr_q;
  assign RAM_A     = a_q;
  assign RAM_D     = d_q;
  assign RSP_VALID = rsp_vld_q;
  assign RSP_DATA  = rsp_q;
endmodule
